// File: rtl/i64_pkg.sv
// i64_pkg: opcodes, trap codes, FSM states and opcode-support helper for the i64 sequencer
package i64_pkg;
  localparam logic [7:0] OP_I64_EQZ  = 8'h50;
  localparam logic [7:0] OP_I64_EQ   = 8'h51;
  localparam logic [7:0] OP_I64_NE   = 8'h52;
  localparam logic [7:0] OP_I64_LT_S = 8'h53;
  localparam logic [7:0] OP_I64_LT_U = 8'h54;
  localparam logic [7:0] OP_I64_GT_S = 8'h55;
  localparam logic [7:0] OP_I64_GT_U = 8'h56;
  localparam logic [7:0] OP_I64_LE_S = 8'h57;
  localparam logic [7:0] OP_I64_LE_U = 8'h58;
  localparam logic [7:0] OP_I64_GE_S = 8'h59;
  localparam logic [7:0] OP_I64_GE_U = 8'h5A;
  localparam logic [7:0] OP_I64_ADD  = 8'h7C;
  localparam logic [7:0] OP_I64_SUB  = 8'h7D;
  localparam logic [7:0] OP_I64_AND  = 8'h83;
  localparam logic [7:0] OP_I64_OR   = 8'h84;
  localparam logic [7:0] OP_I64_XOR  = 8'h85;

  typedef enum logic [2:0] {
    TRAP_NONE      = 3'd0,
    TRAP_UNDERFLOW = 3'd1,
    TRAP_INVALID   = 3'd2,
    TRAP_OVERFLOW  = 3'd3
  } trap_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP_B,
    S_POP_A,
    S_EXEC,
    S_PUSH,
    S_DONE,
    S_TRAP
  } state_e;

  function automatic logic is_supported(input logic [7:0] op);
    return (op >= OP_I64_EQZ && op <= OP_I64_GE_U) || op == OP_I64_ADD || op == OP_I64_SUB ||
           op == OP_I64_AND || op == OP_I64_OR || op == OP_I64_XOR;
  endfunction

  function automatic logic is_compare(input logic [7:0] op);
    return op >= OP_I64_EQZ && op <= OP_I64_GE_U;
  endfunction
endpackage

// File: rtl/i64_alu.sv
// i64_alu: combinational a OP b for i64 eqz/compare/add/sub/and/or/xor; eqz tests b
module i64_alu
  import i64_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);
  logic eq, lt_s, lt_u, gt_s, gt_u, flag;
  logic [WIDTH-1:0] arith;
  assign eq   = a == b;
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;
  assign gt_s = $signed(b) < $signed(a);
  assign gt_u = b < a;
  always_comb begin
    flag  = 1'b0;
    arith = '0;
    case (opcode)
      OP_I64_EQZ:  flag = b == '0;
      OP_I64_EQ:   flag = eq;
      OP_I64_NE:   flag = !eq;
      OP_I64_LT_S: flag = lt_s;
      OP_I64_LT_U: flag = lt_u;
      OP_I64_GT_S: flag = gt_s;
      OP_I64_GT_U: flag = gt_u;
      OP_I64_LE_S: flag = !gt_s;
      OP_I64_LE_U: flag = !gt_u;
      OP_I64_GE_S: flag = !lt_s;
      OP_I64_GE_U: flag = !lt_u;
      OP_I64_ADD:  arith = a + b;
      OP_I64_SUB:  arith = a - b;
      OP_I64_AND:  arith = a & b;
      OP_I64_OR:   arith = a | b;
      OP_I64_XOR:  arith = a ^ b;
      default:     arith = '0;
    endcase
  end
  assign result = is_compare(opcode) ? WIDTH'(flag) : arith;
endmodule

// File: rtl/i64_binop_sequencer.sv
// i64_binop_sequencer: accepts an opcode from decode (op_valid/op_ready), pops operands via stack_pop, pushes the result via stack_push/stack_wdata, pulses done or raises a sticky trap
module i64_binop_sequencer
  import i64_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DEPTH_W    = 10,
  parameter int STACK_SIZE = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [7:0]         opcode,
  input  logic [WIDTH-1:0]   stack_top,
  input  logic [DEPTH_W:0]   stack_depth,
  output logic               stack_pop,
  output logic               stack_push,
  output logic [WIDTH-1:0]   stack_wdata,
  output logic               done,
  output logic [2:0]         trap
);
  state_e state, state_n;
  trap_e trap_q, trap_n;
  logic [7:0] op_q;
  logic [WIDTH-1:0] a, b, res_q, wdata_q, alu_res;
  logic [DEPTH_W:0] need;

  i64_alu #(.WIDTH(WIDTH)) u_alu (
    .opcode(op_q),
    .a(a),
    .b(b),
    .result(alu_res)
  );

  assign need        = opcode == OP_I64_EQZ ? (DEPTH_W+1)'(1) : (DEPTH_W+1)'(2);
  assign trap        = trap_q;
  assign stack_wdata = stack_push ? res_q : wdata_q;

  always_comb begin
    state_n    = state;
    trap_n     = trap_q;
    op_ready   = 1'b0;
    stack_pop  = 1'b0;
    stack_push = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          state_n = !is_supported(opcode) || stack_depth < need ? S_TRAP : S_POP_B;
          trap_n  = !is_supported(opcode) ? TRAP_INVALID : stack_depth < need ? TRAP_UNDERFLOW : TRAP_NONE;
        end
      end
      S_POP_B: begin
        stack_pop = 1'b1;
        state_n   = op_q == OP_I64_EQZ ? S_EXEC : S_POP_A;
      end
      S_POP_A: begin
        stack_pop = 1'b1;
        state_n   = S_EXEC;
      end
      S_EXEC: state_n = S_PUSH;
      S_PUSH: begin
        stack_push = stack_depth != (DEPTH_W+1)'(STACK_SIZE);
        state_n    = stack_push ? S_DONE : S_TRAP;
        trap_n     = stack_push ? trap_q : TRAP_OVERFLOW;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      S_TRAP: state_n = S_TRAP;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trap_q  <= TRAP_NONE;
      op_q    <= '0;
      a       <= '0;
      b       <= '0;
      res_q   <= '0;
      wdata_q <= '0;
    end else begin
      trap_q <= trap_n;
      if (state == S_IDLE && op_valid) op_q <= opcode;
      if (state == S_POP_B) b <= stack_top;
      if (state == S_POP_A) a <= stack_top;
      if (state == S_EXEC) res_q <= alu_res;
      if (stack_push) wdata_q <= res_q;
    end
  end
endmodule

// File: tb/tb_i64_binop_sequencer.sv
// tb_i64_binop_sequencer: directed scoreboard bench with a behavioural operand stack
module tb_i64_binop_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic op_valid;
  logic op_ready;
  logic [7:0] opcode;
  logic [63:0] stack_top;
  logic [10:0] stack_depth;
  logic stack_pop, stack_push, done;
  logic [63:0] stack_wdata;
  logic [2:0] trap;

  i64_binop_sequencer dut (
    .clk(clk),
    .reset(reset),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .opcode(opcode),
    .stack_top(stack_top),
    .stack_depth(stack_depth),
    .stack_pop(stack_pop),
    .stack_push(stack_push),
    .stack_wdata(stack_wdata),
    .done(done),
    .trap(trap)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:63];
  int depth = 0;
  int n_pop = 0, n_push = 0, n_done = 0, n_both = 0;
  logic [63:0] last_push = '0;
  logic tb_clr = 1'b0, tb_push = 1'b0;
  logic [63:0] tb_data = '0;

  assign stack_top   = depth > 0 ? mem[depth-1] : 64'd0;
  assign stack_depth = 11'(depth);

  always @(posedge clk) begin
    if (tb_clr) begin
      depth  <= 0;
      n_pop  <= 0;
      n_push <= 0;
      n_done <= 0;
    end else begin
      if (tb_push && depth < 63) begin
        mem[depth] <= tb_data;
        depth <= depth + 1;
      end
      if (stack_pop && depth > 0) depth <= depth - 1;
      if (stack_push && depth < 63) begin
        mem[depth] <= stack_wdata;
        depth <= depth + 1;
        last_push <= stack_wdata;
      end
      if (stack_pop) n_pop <= n_pop + 1;
      if (stack_push) n_push <= n_push + 1;
      if (done) n_done <= n_done + 1;
    end
    if (stack_pop && stack_push) n_both <= n_both + 1;
  end

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [63:0] x, input logic [63:0] y, input int n);
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
    if (n > 0) begin
      tb_push = 1'b1;
      tb_data = x;
      @(negedge clk);
      if (n > 1) begin
        tb_data = y;
        @(negedge clk);
      end
      tb_push = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] op, input logic [63:0] exp,
                        input int exp_c, input int exp_pops);
    int c;
    chk({tag, "_ready"}, 64'(op_ready), 64'd1);
    opcode = op;
    op_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    opcode = 8'h00;
    op_valid = 1'b0;
    @(negedge clk);
    c = 1;
    while (!done && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_latency"}, 64'(c), 64'(exp_c));
    chk({tag, "_pops"}, 64'(n_pop), 64'(exp_pops));
    chk({tag, "_pushes"}, 64'(n_push), 64'd1);
    chk({tag, "_result"}, last_push, exp_q.pop_front());
    chk({tag, "_depth"}, 64'(depth), 64'd1);
    chk({tag, "_trap"}, 64'(trap), 64'd0);
    @(negedge clk);
    chk({tag, "_ready_after"}, 64'(op_ready), 64'd1);
    chk({tag, "_done_once"}, 64'(n_done), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_trap", 64'(trap), 64'd0);
    chk("rst_ready", 64'(op_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    op_valid = 1'b0;
    opcode = 8'h00;
    #2;
    chk("reset_ready", 64'(op_ready), 64'd1);
    chk("reset_pop", 64'(stack_pop), 64'd0);
    chk("reset_push", 64'(stack_push), 64'd0);
    chk("reset_wdata", stack_wdata, 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_trap", 64'(trap), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    load(64'd5, 64'd3, 2);
    run_op("ne_diff", 8'h52, 64'd1, 5, 2);
    load(64'd7, 64'd7, 2);
    run_op("ne_same", 8'h52, 64'd0, 5, 2);
    load(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2);
    run_op("lt_s", 8'h53, 64'd1, 5, 2);
    load(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2);
    run_op("lt_u", 8'h54, 64'd0, 5, 2);
    load(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2);
    run_op("add_wrap", 8'h7C, 64'd1, 5, 2);
    load(64'd3, 64'd5, 2);
    run_op("sub", 8'h7D, 64'hFFFF_FFFF_FFFF_FFFE, 5, 2);
    load(64'd0, 64'd0, 1);
    run_op("eqz_zero", 8'h50, 64'd1, 4, 1);
    load(64'd9, 64'd0, 1);
    run_op("eqz_nine", 8'h50, 64'd0, 4, 1);
    load(64'd4, 64'h8000_0000_0000_0000, 2);
    run_op("gt_s", 8'h55, 64'd1, 5, 2);
    load(64'hC, 64'hA, 2);
    run_op("and", 8'h83, 64'h8, 5, 2);
    chk("wdata_hold", stack_wdata, 64'h8);

    load(64'hF0, 64'h0F, 2);
    opcode = 8'h85;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_ready", 64'(op_ready), 64'd1);
    chk("midrst_pop", 64'(stack_pop), 64'd0);
    chk("midrst_push", 64'(stack_push), 64'd0);
    chk("midrst_wdata", stack_wdata, 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_trap", 64'(trap), 64'd0);
    repeat (3) @(negedge clk);
    chk("midrst_no_push", 64'(n_push), 64'd0);
    chk("midrst_no_done", 64'(n_done), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    load(64'hF0, 64'h0F, 2);
    run_op("xor", 8'h85, 64'hFF, 5, 2);

    load(64'd5, 64'd0, 1);
    opcode = 8'h51;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("uflow_trap", 64'(trap), 64'd1);
    chk("uflow_ready", 64'(op_ready), 64'd0);
    chk("uflow_pops", 64'(n_pop), 64'd0);
    chk("uflow_pushes", 64'(n_push), 64'd0);
    op_valid = 1'b1;
    repeat (2) @(negedge clk);
    op_valid = 1'b0;
    chk("uflow_sticky", 64'(trap), 64'd1);
    do_reset();

    load(64'd1, 64'd2, 2);
    opcode = 8'h00;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("inval_trap", 64'(trap), 64'd2);
    chk("inval_ready", 64'(op_ready), 64'd0);
    chk("inval_pops", 64'(n_pop), 64'd0);
    chk("inval_pushes", 64'(n_push), 64'd0);
    do_reset();

    chk("pop_push_overlap", 64'(n_both), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
